// File: rtl/store_result_monitor.sv
// Hardware pass/fail/timeout checker for the pipelined MIPS data-memory write port.
// Optional store log (8-entry circular buffer) is enabled by defining STORE_MONITOR_LOG_EN.
module store_result_monitor #(
  parameter logic [31:0] PASS_ADDR      = 32'd84,
  parameter logic [31:0] PASS_DATA      = 32'd7,
  parameter logic [31:0] ALLOW_ADDR     = 32'd80,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd10000,
  parameter int          CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memwrite,
  input  logic [31:0]      dataadr,
  input  logic [31:0]      writedata,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [CNT_W-1:0] store_count,
  output logic [31:0]      cycle_count,
  output logic [31:0]      fail_addr,
  output logic [31:0]      fail_data
`ifdef STORE_MONITOR_LOG_EN
  ,
  input  logic [2:0]       log_idx,
  output logic [31:0]      log_addr,
  output logic [31:0]      log_data,
  output logic             log_valid
`endif
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic   capture;
  logic   in_run;
  logic   store_run;
  logic   hit_pass_addr;
  logic   hit_allow_addr;
  logic   last_cycle;

  assign in_run         = (state == ST_RUN);
  assign store_run      = in_run && memwrite;
  assign hit_pass_addr  = (dataadr == PASS_ADDR);
  assign hit_allow_addr = (dataadr == ALLOW_ADDR);
  assign last_cycle     = (cycle_count == TIMEOUT_CYCLES - 32'd1);

  // Store checks outrank the timeout, so a terminating store on the last cycle decides the run.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that skips an assignment would infer a latch.
    state_nxt = state;
    capture   = 1'b0;
    if (in_run) begin
      if (memwrite && hit_pass_addr && (writedata == PASS_DATA)) begin
        state_nxt = ST_PASS;
      end else if (memwrite && (hit_pass_addr || !hit_allow_addr)) begin
        state_nxt = ST_FAIL;
        capture   = 1'b1;
      end else if (last_cycle) begin
        state_nxt = ST_TIMEOUT;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_RUN;
      done    <= 1'b0;
      pass    <= 1'b0;
      fail    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      done    <= (state_nxt != ST_RUN);
      pass    <= (state_nxt == ST_PASS);
      fail    <= (state_nxt == ST_FAIL);
      timeout <= (state_nxt == ST_TIMEOUT);
    end
  end

  // Counters only move in RUN; the terminating edge itself is still a RUN edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      store_count <= '0;
      cycle_count <= '0;
      fail_addr   <= '0;
      fail_data   <= '0;
    end else if (in_run) begin
      cycle_count <= cycle_count + 32'd1;
      if (memwrite && (store_count != '1)) begin
        store_count <= store_count + 1'b1;
      end
      if (capture) begin
        fail_addr <= dataadr;
        fail_data <= writedata;
      end
    end
  end

`ifdef STORE_MONITOR_LOG_EN
  logic [63:0] log_mem [8];
  logic [2:0]  log_wptr;
  logic [7:0]  log_vld;
  logic [2:0]  log_slot;

  always_ff @(posedge clk) begin
    if (reset) begin
      log_wptr <= '0;
      log_vld  <= '0;
    end else if (store_run) begin
      log_wptr           <= log_wptr + 3'd1;
      log_vld[log_wptr]  <= 1'b1;
    end
  end

  // NOTE: the log array has no reset; the valid bits alone say which entries are meaningful.
  always_ff @(posedge clk) begin
    if (!reset && store_run) begin
      log_mem[log_wptr] <= {dataadr, writedata};
    end
  end

  // Index 0 is the most recent store, i.e. the slot just behind the write pointer.
  assign log_slot  = log_wptr - 3'd1 - log_idx;
  assign log_addr  = log_mem[log_slot][63:32];
  assign log_data  = log_mem[log_slot][31:0];
  assign log_valid = log_vld[log_slot];
`endif

endmodule
